// File: rtl/ic_sweep_pkg.sv
// Shared types, sizes and the bvand/bvugt predicate used by the IC sweep checkers.
package ic_sweep_pkg;

  localparam int SWEEP_W = 4;
  localparam int NPAIR   = 1 << (2 * SWEEP_W);
  localparam int NX      = 1 << SWEEP_W;
  // Wide enough for any operand width these checkers are built with.
  localparam int FW      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_XLOOP  = 3'd2,
    ST_CMP    = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // Operands arrive zero-extended, so the wide compare equals the W-bit unsigned compare.
  function automatic logic ugt_and(input logic [FW-1:0] x,
                                   input logic [FW-1:0] s,
                                   input logic [FW-1:0] t);
    return ((x & s) > t);
  endfunction

endpackage

// File: rtl/ic_bvand_ugt_golden.sv
// Serial golden accumulator: ORs ((x & s) >u t) over x = 0 .. 2^W-1, one x per enabled cycle.
// last flags the cycle in which the final x value is being processed.
module ic_bvand_ugt_golden
  import ic_sweep_pkg::*;
#(
  parameter int W = SWEEP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         acc,
  output logic         last
);

  // One extra bit keeps the final x distinguishable from the post-loop value.
  localparam logic [W:0] XMAX = {1'b0, {W{1'b1}}};

  logic [W:0] x_q, x_d;
  logic       acc_q, acc_d;

  always_comb begin
    x_d   = x_q;
    acc_d = acc_q;
    if (clr) begin
      x_d   = '0;
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q | ugt_and(FW'(x_q[W-1:0]), FW'(s), FW'(t));
      x_d   = x_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      acc_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      acc_q <= acc_d;
    end
  end

  assign acc  = acc_q;
  assign last = (x_q == XMAX);

endmodule

// File: rtl/ic_bvugt_bvand_sweep_checker.sv
// Exhaustive (s,t) sweep that checks a downstream bvugt/bvand Skolem block against a serial golden.
// Per pair: SETTLE cycles hold, 2^W golden cycles, 1 compare cycle; start is ignored while busy.
module ic_bvugt_bvand_sweep_checker
  import ic_sweep_pkg::*;
#(
  parameter int W      = SWEEP_W,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [2*W-1:0] cand_vec,
  input  logic           skolem_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic [2*W-1:0] first_err_vec,
  output logic           first_err_got
);

  localparam int             SCW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE - 1);

  state_t         state_q, state_d;
  logic [2*W-1:0] cand_q, cand_d;
  logic [2*W:0]   err_q, err_d;
  logic [2*W-1:0] fvec_q, fvec_d;
  logic           fgot_q, fgot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           samp_q, samp_d;
  logic           xfirst_q, xfirst_d;

  logic gold_clr, gold_en, gold_acc, gold_last;

  assign gold_clr = (state_q == ST_SETTLE) && (scnt_q == SC_LAST);
  assign gold_en  = (state_q == ST_XLOOP);

  ic_bvand_ugt_golden #(.W(W)) u_golden (
    .clk  (clk),
    .rst  (rst),
    .clr  (gold_clr),
    .en   (gold_en),
    .s    (cand_q[W-1:0]),
    .t    (cand_q[2*W-1:W]),
    .acc  (gold_acc),
    .last (gold_last)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fgot_d   = fgot_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    scnt_d   = scnt_q;
    xfirst_d = 1'b0;
    // The Skolem output is captured once, SETTLE cycles after cand_vec last moved.
    samp_d   = (state_q == ST_XLOOP && xfirst_q) ? skolem_in : samp_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cand_d  = '0;
          err_d   = '0;
          fvec_d  = '0;
          fgot_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          scnt_d  = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt_q == SC_LAST) begin
          xfirst_d = 1'b1;
          state_d  = ST_XLOOP;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_XLOOP: begin
        if (gold_last) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (samp_q != gold_acc) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fvec_d = cand_q;
            fgot_d = samp_q;
          end
        end
        if (cand_q == '1) begin
          state_d = ST_FIN;
        end else begin
          cand_d  = cand_q + 1'b1;
          scnt_d  = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      err_q    <= '0;
      fvec_q   <= '0;
      fgot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      scnt_q   <= '0;
      samp_q   <= 1'b0;
      xfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fgot_q   <= fgot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      scnt_q   <= scnt_d;
      samp_q   <= samp_d;
      xfirst_q <= xfirst_d;
    end
  end

  assign cand_vec      = cand_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_vec = fvec_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_ic_bvugt_bvand_sweep_checker.sv
// Directed bench: golden, stuck-at, start-spam, mid-sweep reset and settle-latency scenarios.
module tb_ic_bvugt_bvand_sweep_checker;
  import ic_sweep_pkg::*;

  localparam int LIMIT = 8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode_a = 2'd0;

  logic [7:0] cand_a, cand_b, fvec_a, fvec_b;
  logic [8:0] err_a, err_b;
  logic busy_a, done_a, pass_a, fgot_a, skol_a;
  logic busy_b, done_b, pass_b, fgot_b, skol_b;
  logic [2:0] dly_a, dly_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference Skolem answer: exists x with (x & s) > t  <=>  s > t.
  always @(posedge clk) begin
    dly_a <= {dly_a[1:0], (cand_a[3:0] > cand_a[7:4])};
    dly_b <= {dly_b[1:0], (cand_b[3:0] > cand_b[7:4])};
  end

  always_comb begin
    case (mode_a)
      2'd0:    skol_a = (cand_a[3:0] > cand_a[7:4]);
      2'd1:    skol_a = 1'b0;
      2'd2:    skol_a = 1'b1;
      default: skol_a = dly_a[2];
    endcase
  end
  assign skol_b = dly_b[2];

  ic_bvugt_bvand_sweep_checker #(.W(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start_a), .cand_vec(cand_a), .skolem_in(skol_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_vec(fvec_a), .first_err_got(fgot_a)
  );

  ic_bvugt_bvand_sweep_checker #(.W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start_b), .cand_vec(cand_b), .skolem_in(skol_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_vec(fvec_b), .first_err_got(fgot_b)
  );

  // Starts a sweep on dut and counts edges from the accept edge until done is seen.
  task automatic run_a(input bit pulse, input int stop_at, output int cyc,
                       output logic busy0, output logic done0);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    busy0 = busy_a;
    done0 = done_a;
    cyc = 0;
    while (cyc < LIMIT && cyc < stop_at) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done_a) begin
        start_a = 1'b0;
        break;
      end
      start_a = pulse && ((cyc % 50) < 3);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, pass_a, err_a, fvec_a, fgot_a, cand_a} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b pass=%b err=%0d fvec=%h got=%b cand=%h want all 0",
               busy_a, done_a, pass_a, err_a, fvec_a, fgot_a, cand_a);
    end
    n_checks++;
    if ({busy_b, done_b, pass_b, err_b} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_s3 got busy=%b done=%b pass=%b err=%0d want all 0",
               busy_b, done_b, pass_b, err_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_golden();
    int cyc; logic b0, d0;
    mode_a = 2'd0;
    run_a(1'b0, LIMIT, cyc, b0, d0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL golden_busy got %b want 1", b0); end
    n_checks++;
    if (cyc !== 4609) begin n_fail++; $display("FAIL golden_cycles got %0d want 4609", cyc); end
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL golden_done got done=%b busy=%b want done=1 busy=0", done_a, busy_a);
    end
    n_checks++;
    if (pass_a !== 1'b1 || err_a !== 9'd0 || fvec_a !== 8'h00) begin
      n_fail++; $display("FAIL golden_result got pass=%b err=%0d fvec=%h want 1 0 00", pass_a, err_a, fvec_a);
    end
  endtask

  task automatic test_stuck0();
    int cyc; logic b0, d0;
    mode_a = 2'd1;
    run_a(1'b0, LIMIT, cyc, b0, d0);
    n_checks++;
    if (d0 !== 1'b0) begin n_fail++; $display("FAIL stuck0_done_clear got %b want 0", d0); end
    n_checks++;
    if (err_a !== 9'd120 || pass_a !== 1'b0) begin
      n_fail++; $display("FAIL stuck0_count got err=%0d pass=%b want 120 0", err_a, pass_a);
    end
    n_checks++;
    if (fvec_a !== 8'h01 || fgot_a !== 1'b0) begin
      n_fail++; $display("FAIL stuck0_first got vec=%h got=%b want 01 0", fvec_a, fgot_a);
    end
  endtask

  task automatic test_stuck1();
    int cyc; logic b0, d0;
    mode_a = 2'd2;
    run_a(1'b0, LIMIT, cyc, b0, d0);
    n_checks++;
    if (err_a !== 9'd136 || pass_a !== 1'b0 || done_a !== 1'b1) begin
      n_fail++; $display("FAIL stuck1_count got err=%0d pass=%b done=%b want 136 0 1", err_a, pass_a, done_a);
    end
    n_checks++;
    if (fvec_a !== 8'h00 || fgot_a !== 1'b1) begin
      n_fail++; $display("FAIL stuck1_first got vec=%h got=%b want 00 1", fvec_a, fgot_a);
    end
  endtask

  task automatic test_start_spam();
    int cyc; logic b0, d0;
    mode_a = 2'd0;
    run_a(1'b1, LIMIT, cyc, b0, d0);
    n_checks++;
    if (cyc !== 4609) begin n_fail++; $display("FAIL spam_cycles got %0d want 4609", cyc); end
    n_checks++;
    if (pass_a !== 1'b1 || err_a !== 9'd0 || fvec_a !== 8'h00 || fgot_a !== 1'b0) begin
      n_fail++; $display("FAIL spam_result got pass=%b err=%0d fvec=%h got=%b want 1 0 00 0",
                         pass_a, err_a, fvec_a, fgot_a);
    end
  endtask

  task automatic test_mid_reset();
    int cyc; logic b0, d0;
    mode_a = 2'd1;
    run_a(1'b0, 1000, cyc, b0, d0);
    n_checks++;
    if (busy_a !== 1'b1 || err_a === 9'd0) begin
      n_fail++; $display("FAIL midrst_pre got busy=%b err=%0d want busy=1 err>0", busy_a, err_a);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({busy_a, done_a, pass_a, err_a, fvec_a, fgot_a, cand_a} !== 28'd0) begin
      n_fail++; $display("FAIL midrst_outputs got busy=%b done=%b err=%0d cand=%h want all 0",
                         busy_a, done_a, err_a, cand_a);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL midrst_state got %0d want %0d", dut.state_q, ST_IDLE);
    end
    mode_a = 2'd0;
    run_a(1'b0, LIMIT, cyc, b0, d0);
    n_checks++;
    if (cyc !== 4609 || pass_a !== 1'b1 || err_a !== 9'd0) begin
      n_fail++; $display("FAIL midrst_rerun got cyc=%0d pass=%b err=%0d want 4609 1 0", cyc, pass_a, err_a);
    end
  endtask

  task automatic test_settle();
    int cyc; logic b0, d0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 0;
    while (cyc < LIMIT) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done_b) break;
    end
    n_checks++;
    if (cyc !== 5121) begin n_fail++; $display("FAIL settle3_cycles got %0d want 5121", cyc); end
    n_checks++;
    if (pass_b !== 1'b1 || err_b !== 9'd0) begin
      n_fail++; $display("FAIL settle3_result got pass=%b err=%0d want 1 0", pass_b, err_b);
    end
    mode_a = 2'd3;
    run_a(1'b0, LIMIT, cyc, b0, d0);
    n_checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b0 || err_a === 9'd0) begin
      n_fail++; $display("FAIL settle1_delayed got done=%b pass=%b err=%0d want 1 0 >0", done_a, pass_a, err_a);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck0();
    test_stuck1();
    test_start_spam();
    test_mid_reset();
    test_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
